bus_arbiter: RTL and testbench
==============================

// Module: bus_arbiter
// PURPOSE
//  Parametrised bus-cycle sequencer for the shared system bus (RAM, I/O, address/data/RW lines).
//  Generates phi2 and splits each CPU cycle into an AUX half (phi2 low) and a CPU half (phi2 high).
//  The AUX half is granted round-robin to NUM_REQ requesters (SPI/Pi, video, future DMA) over a
//  pending/done handshake. Replaces the hard-wired Pi/video slotting with N generic channels.
// PARAMETERS
//  NUM_REQ     3   number of aux requesters (1..8)
//  ADDR_W      17  bus address width
//  DATA_W      8   bus data width
//  CYCLE_CLKS  16  clk_i periods per CPU cycle; even, >=8; each half is H = CYCLE_CLKS/2
// PORTS
//  clk_i           in   1                  main clock (16 MHz)
//  reset_ni        in   1                  asynchronous, active-low reset
//  cpu_ready_i     in   1                  1 = CPU running, 0 = halted
//  req_pending_i   in   NUM_REQ            level request per channel
//  req_rw_b_i      in   NUM_REQ            1 = read, 0 = write
//  req_addr_i      in   NUM_REQ x ADDR_W   request address (packed array)
//  req_wr_data_i   in   NUM_REQ x DATA_W   write data
//  bus_data_i      in   DATA_W             bus data, sampled on reads
//  phi2_o          out  1                  CPU clock
//  cpu_en_o        out  1                  1 = CPU owns the bus this half
//  grant_o         out  NUM_REQ            one-hot aux owner for the current slot
//  bus_rw_b_o      out  1                  RW driven during a granted aux slot
//  bus_addr_o      out  ADDR_W             address driven during a granted aux slot
//  bus_addr_oe_o   out  1                  drive enable for bus_addr_o and bus_rw_b_o
//  bus_data_o      out  DATA_W             write data
//  bus_data_oe_o   out  1                  drive enable for bus_data_o
//  ram_oe_o        out  1                  RAM read strobe (aux reads only)
//  ram_we_o        out  1                  RAM write strobe (aux writes only)
//  rd_data_o       out  DATA_W             captured read data; valid with done_o, held until next read
//  done_o          out  NUM_REQ            1-clock completion pulse per channel
// BEHAVIOUR
//  Reset: phi2_o=0, cpu_en_o=0, grant_o=0, bus_rw_b_o=1, all *_oe_o/ram_*_o/done_o=0, rd_data_o=0.
//    Also clears the slot counter (next slot starts at AUX clock 0) and the RR pointer (=0).
//  Slot counter cnt runs 0..CYCLE_CLKS-1 and wraps.
//    cnt < H: AUX half, phi2_o=0, cpu_en_o=0.
//    cnt >= H: CPU half, phi2_o=1, cpu_en_o=1.
//  AUX clock 0: sample req_pending_i. Winner = first pending channel at or after the RR pointer,
//    modulo NUM_REQ. Latch the winner's rw/addr/data for the whole slot, assert grant_o and
//    bus_addr_oe_o, and drive bus_data_oe_o=1 for writes.
//  AUX clocks 1..H-3: ram_oe_o (read) or ram_we_o (write) asserted.
//  AUX clock H-2: read data captured into rd_data_o; strobes drop.
//  AUX clock H-1: done_o[winner] pulses; all drives release; RR pointer = winner+1 (wraps).
//  Total latency: pending seen at slot start -> done at +H-1 clocks. Worst case NUM_REQ CPU cycles.
//  Handshake: the requester holds pending and inputs stable until done, then drops pending within
//    H clocks. Pending still high at the next slot start is a new request.
//  Pending dropped mid-slot: ignored; the latched transaction completes and done still pulses.
//  No pending at clock 0: idle slot. No grant, no strobe, no done; RR pointer unchanged.
//  All channels pending: service order 0,1,2,0,... and no channel is starved.
//  Reset mid-slot: transaction aborted, no done, strobes drop immediately (async).
//  CPU half: no aux outputs active; CPU decode owns strobes.
// CONFIGURATION
//  BUS_ARB_CPU_STEAL_EN defined:
//    While cpu_ready_i=0 at clock H, the CPU half runs as a second AUX slot with identical
//    sequencing. phi2_o still toggles, cpu_en_o stays 0, and the RR pointer advances across both
//    slots. A cpu_ready_i rise mid-slot takes effect at the next clock H.
//  BUS_ARB_CPU_STEAL_EN undefined: the CPU half is never granted to aux; cpu_ready_i is unused.
// STRUCTURE
//  bus_arb_pkg: slot_phase_e enum (AUX_ADDR, AUX_STROBE, AUX_CAPTURE, AUX_DONE, CPU),
//    localparam helpers for H and strobe/capture/done offsets, and the request struct
//    {rw_b, addr, data}.
//  Sub-module rr_arbiter #(N): pending vector + pointer -> one-hot grant and valid (combinational).
// TESTING
//  1. Reset released, no pending -> phi2_o period 16 clocks, 50% duty; grant_o/strobes stay 0.
//  2. Ch0 read of 17'h08000, bus_data_i=8'hA5 -> ram_oe_o clocks 1..5, rd_data_o=8'hA5,
//     done_o=3'b001 at AUX clock 7.
//  3. Ch1 write 8'h3C to 17'h0E80E -> bus_data_oe_o=1, ram_we_o clocks 1..5, done_o[1] pulse,
//     ram_oe_o never set.
//  4. All three pending continuously -> grants 001,010,100,001 over 4 CPU cycles.
//  5. reset_ni low at AUX clock 3 of a write -> ram_we_o drops at once, no done_o;
//     grant restarts at ch0 after reset.
//  6. (CPU_STEAL_EN) cpu_ready_i=0, ch0 and ch2 pending -> both serviced in one CPU cycle,
//     cpu_en_o stays 0.

Source files
------------

// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg: slot phases and slot-offset helpers shared by the bus arbiter
package bus_arb_pkg;
    typedef enum logic [2:0] {AUX_ADDR, AUX_STROBE, AUX_CAPTURE, AUX_DONE, CPU} slot_phase_e;
    localparam int STROBE_FIRST = 1;
    function automatic int half_clks(input int cycle_clks);
        return cycle_clks / 2;
    endfunction
    function automatic int strobe_last(input int h);
        return h - 3;
    endfunction
    function automatic int capture_off(input int h);
        return h - 2;
    endfunction
    function automatic int done_off(input int h);
        return h - 1;
    endfunction
endpackage

// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: requester handshake and shared-bus signals of the bus arbiter
interface bus_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 17,
    parameter int DATA_W  = 8
);
    logic                           cpu_ready_i;
    logic [NUM_REQ-1:0]             req_pending_i;
    logic [NUM_REQ-1:0]             req_rw_b_i;
    logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr_i;
    logic [NUM_REQ-1:0][DATA_W-1:0] req_wr_data_i;
    logic [DATA_W-1:0]              bus_data_i;
    logic                           phi2_o;
    logic                           cpu_en_o;
    logic [NUM_REQ-1:0]             grant_o;
    logic                           bus_rw_b_o;
    logic [ADDR_W-1:0]              bus_addr_o;
    logic                           bus_addr_oe_o;
    logic [DATA_W-1:0]              bus_data_o;
    logic                           bus_data_oe_o;
    logic                           ram_oe_o;
    logic                           ram_we_o;
    logic [DATA_W-1:0]              rd_data_o;
    logic [NUM_REQ-1:0]             done_o;
    modport master (
        input  cpu_ready_i, req_pending_i, req_rw_b_i, req_addr_i, req_wr_data_i, bus_data_i,
        output phi2_o, cpu_en_o, grant_o, bus_rw_b_o, bus_addr_o, bus_addr_oe_o, bus_data_o,
               bus_data_oe_o, ram_oe_o, ram_we_o, rd_data_o, done_o
    );
    modport slave (
        output cpu_ready_i, req_pending_i, req_rw_b_i, req_addr_i, req_wr_data_i, bus_data_i,
        input  phi2_o, cpu_en_o, grant_o, bus_rw_b_o, bus_addr_o, bus_addr_oe_o, bus_data_o,
               bus_data_oe_o, ram_oe_o, ram_we_o, rd_data_o, done_o
    );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: picks the first pending channel at or after ptr, wrapping modulo N
module rr_arbiter #(
    parameter int N  = 3,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  pend,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] idx,
    output logic          valid
);
    int k;
    // scan farthest-to-nearest so the channel closest to ptr is the last one written
    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        k     = 0;
        for (int i = N - 1; i >= 0; i--) begin
            k = (int'(ptr) + i) % N;
            if (pend[k]) begin
                grant = N'(1) << k;
                idx   = PW'(k);
                valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: phi2 generator and round-robin AUX slot sequencer; BUS_ARB_CPU_STEAL_EN lends halted CPU halves to aux
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int NUM_REQ    = 3,
    parameter int ADDR_W     = 17,
    parameter int DATA_W     = 8,
    parameter int CYCLE_CLKS = 16
) (
    input logic           clk_i,
    input logic           reset_ni,
    bus_arbiter_if.master bus
);
    localparam int H  = half_clks(CYCLE_CLKS);
    localparam int CW = $clog2(CYCLE_CLKS);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [CW-1:0] HC = CW'(H);
    typedef struct packed {
        logic              rw_b;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } req_t;
    logic [CW-1:0]      cnt_q, cnt_n, loc;
    logic               act_q, steal_q, steal_n, start, valid_c, drive;
    logic [PW-1:0]      ptr_q, ptr_n, win_q, win_c;
    logic [NUM_REQ-1:0] grant_q, grant_c;
    logic [DATA_W-1:0]  rd_q;
    req_t               req_q;
    slot_phase_e        phase;
    assign loc = (cnt_q >= HC) ? cnt_q - HC : cnt_q;
    rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_rr (
        .pend  (bus.req_pending_i),
        .ptr   (ptr_n),
        .grant (grant_c),
        .idx   (win_c),
        .valid (valid_c)
    );
    // slot timing, steal decision, phase decode and the pointer the next slot arbitrates from
    always_comb begin
        cnt_n = (cnt_q == CW'(CYCLE_CLKS - 1)) ? '0 : cnt_q + 1'b1;
`ifdef BUS_ARB_CPU_STEAL_EN
        steal_n = (cnt_n == HC) ? !bus.cpu_ready_i : (cnt_n == '0) ? 1'b0 : steal_q;
`else
        steal_n = 1'b0;
`endif
        start = (cnt_n == '0) || (cnt_n == HC && steal_n);
        phase = (cnt_q >= HC && !steal_q) ? CPU :
                (loc == '0) ? AUX_ADDR :
                (loc <= CW'(strobe_last(H))) ? AUX_STROBE :
                (loc == CW'(capture_off(H))) ? AUX_CAPTURE : AUX_DONE;
        ptr_n = (act_q && phase == AUX_DONE) ? ((win_q == PW'(NUM_REQ - 1)) ? '0 : win_q + 1'b1) : ptr_q;
    end
    // bus drive and strobe decode from the latched slot owner
    always_comb begin
        drive             = act_q && phase != AUX_DONE;
        bus.phi2_o        = cnt_q >= HC;
        bus.cpu_en_o      = cnt_q >= HC && !steal_q;
        bus.grant_o       = act_q ? grant_q : '0;
        bus.bus_rw_b_o    = drive ? req_q.rw_b : 1'b1;
        bus.bus_addr_o    = req_q.addr;
        bus.bus_addr_oe_o = drive;
        bus.bus_data_o    = req_q.data;
        bus.bus_data_oe_o = drive && !req_q.rw_b;
        bus.ram_oe_o      = act_q && phase == AUX_STROBE && req_q.rw_b;
        bus.ram_we_o      = act_q && phase == AUX_STROBE && !req_q.rw_b;
        bus.rd_data_o     = rd_q;
        bus.done_o        = (act_q && phase == AUX_DONE) ? grant_q : '0;
    end
    // slot state: latch the winner at slot start, retire it after the done clock, capture reads at the last strobe clock
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            cnt_q   <= '0;
            steal_q <= 1'b0;
            act_q   <= 1'b0;
            ptr_q   <= '0;
            win_q   <= '0;
            grant_q <= '0;
            rd_q    <= '0;
            req_q   <= '{rw_b: 1'b1, addr: '0, data: '0};
        end else begin
            cnt_q   <= cnt_n;
            steal_q <= steal_n;
            ptr_q   <= ptr_n;
            if (start) begin
                act_q   <= valid_c;
                win_q   <= win_c;
                grant_q <= grant_c;
                req_q   <= '{rw_b: bus.req_rw_b_i[win_c], addr: bus.req_addr_i[win_c], data: bus.req_wr_data_i[win_c]};
            end else if (phase == AUX_DONE) begin
                act_q <= 1'b0;
            end
            if (act_q && req_q.rw_b && loc == CW'(strobe_last(H))) rd_q <= bus.bus_data_i;
        end
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed scenarios plus randomized traffic checked against a slot-level model
module tb_bus_arbiter;
    localparam int N = 3, AW = 17, DW = 8, C = 16, H = 8;
`ifdef BUS_ARB_CPU_STEAL_EN
    localparam bit STEAL = 1'b1;
`else
    localparam bit STEAL = 1'b0;
`endif
    logic clk = 1'b0, rst_n = 1'b0;
    int vectors = 0, errors = 0;
    bus_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();
    bus_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .CYCLE_CLKS(C)) dut (
        .clk_i    (clk),
        .reset_ni (rst_n),
        .bus      (bus)
    );
    always #5 clk = ~clk;

    // reference model: a slot owner chosen at each slot start from a pending snapshot
    int m_cnt, m_win, m_ptr, m_nc, m_ptr_n, m_pick, m_off;
    bit m_act, m_steal, m_st;
    logic m_rw;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data, m_rd;
    logic exp_phi2, exp_cpu_en, exp_oe, exp_we, exp_addr_oe, exp_data_oe, exp_rw;
    logic [N-1:0] exp_grant, exp_done;
    always_comb begin
        m_off   = m_cnt % H;
        m_nc    = (m_cnt + 1) % C;
        m_st    = (m_nc == H) ? (STEAL && !bus.cpu_ready_i) : (m_nc == 0) ? 1'b0 : m_steal;
        m_ptr_n = (m_act && m_off == H - 1) ? (m_win + 1) % N : m_ptr;
        m_pick  = -1;
        for (int i = 0; i < N; i++)
            if (m_pick < 0 && bus.req_pending_i[(m_ptr_n + i) % N]) m_pick = (m_ptr_n + i) % N;
        exp_phi2    = m_cnt >= H;
        exp_cpu_en  = m_cnt >= H && !m_steal;
        exp_grant   = m_act ? N'(1 << m_win) : '0;
        exp_addr_oe = m_act && m_off != H - 1;
        exp_data_oe = exp_addr_oe && !m_rw;
        exp_rw      = exp_addr_oe ? m_rw : 1'b1;
        exp_oe      = m_act && m_rw && m_off >= 1 && m_off <= H - 3;
        exp_we      = m_act && !m_rw && m_off >= 1 && m_off <= H - 3;
        exp_done    = (m_act && m_off == H - 1) ? exp_grant : '0;
    end
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt <= 0; m_act <= 1'b0; m_steal <= 1'b0; m_ptr <= 0; m_win <= 0;
            m_rd <= '0; m_rw <= 1'b1; m_addr <= '0; m_data <= '0;
        end else begin
            m_cnt   <= m_nc;
            m_steal <= m_st;
            m_ptr   <= m_ptr_n;
            if (m_act && m_rw && m_off == H - 3) m_rd <= bus.bus_data_i;
            if (m_nc == 0 || (m_nc == H && m_st)) begin
                m_act <= m_pick >= 0;
                if (m_pick >= 0) begin
                    m_win  <= m_pick;
                    m_rw   <= bus.req_rw_b_i[m_pick];
                    m_addr <= bus.req_addr_i[m_pick];
                    m_data <= bus.req_wr_data_i[m_pick];
                end
            end else if (m_off == H - 1) begin
                m_act <= 1'b0;
            end
        end
    end

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({bus.phi2_o, bus.cpu_en_o, bus.grant_o, bus.done_o} !== '0) begin
            errors++; $display("FAIL reset_ctl phi2/cpu_en/grant/done=%b/%b/%b/%b want all 0", bus.phi2_o, bus.cpu_en_o, bus.grant_o, bus.done_o);
        end
        vectors++;
        if ({bus.ram_oe_o, bus.ram_we_o, bus.bus_addr_oe_o, bus.bus_data_oe_o} !== 4'b0) begin
            errors++; $display("FAIL reset_strobes oe/we/aoe/doe=%b%b%b%b want 0000", bus.ram_oe_o, bus.ram_we_o, bus.bus_addr_oe_o, bus.bus_data_oe_o);
        end
        vectors++;
        if (bus.bus_rw_b_o !== 1'b1) begin errors++; $display("FAIL reset_rw got %b want 1", bus.bus_rw_b_o); end
        vectors++;
        if (bus.rd_data_o !== '0) begin errors++; $display("FAIL reset_rd got %h want 00", bus.rd_data_o); end
        rst_n = 1'b1;
    endtask

    task automatic test_idle;
        int highs = 0, rises = 0;
        logic prev = 1'b0;
        repeat (32) begin
            @(negedge clk);
            vectors++;
            if (bus.phi2_o !== exp_phi2 || bus.grant_o !== '0 || bus.ram_oe_o !== 1'b0 || bus.ram_we_o !== 1'b0) begin
                errors++; $display("FAIL idle cnt=%0d phi2=%b grant=%b oe=%b we=%b want phi2=%b rest 0", m_cnt, bus.phi2_o, bus.grant_o, bus.ram_oe_o, bus.ram_we_o, exp_phi2);
            end
            highs += int'(bus.phi2_o);
            rises += int'(bus.phi2_o && !prev);
            prev = bus.phi2_o;
        end
        vectors++;
        if (highs != 16 || rises != 2) begin errors++; $display("FAIL idle_phi2_duty highs=%0d rises=%0d want 16/2", highs, rises); end
    endtask

    task automatic test_read;
        int oe_n = 0;
        bit seen = 1'b0;
        bus.req_rw_b_i[0] = 1'b1; bus.req_addr_i[0] = 17'h08000; bus.bus_data_i = 8'hA5; bus.req_pending_i = 3'b001;
        for (int t = 0; t < 48 && !seen; t++) begin
            @(negedge clk);
            if (bus.ram_oe_o) begin
                oe_n++; vectors++;
                if (m_off < 1 || m_off > H - 3 || bus.bus_addr_o !== 17'h08000 || bus.bus_addr_oe_o !== 1'b1 || bus.grant_o !== 3'b001) begin
                    errors++; $display("FAIL read_strobe off=%0d addr=%h aoe=%b grant=%b want off 1..5 addr 08000 aoe 1 grant 001", m_off, bus.bus_addr_o, bus.bus_addr_oe_o, bus.grant_o);
                end
            end
            if (bus.done_o !== '0) begin
                seen = 1'b1; vectors++;
                if (bus.done_o !== 3'b001 || m_off != H - 1 || bus.rd_data_o !== 8'hA5) begin
                    errors++; $display("FAIL read_done done=%b off=%0d rd=%h want 001/7/a5", bus.done_o, m_off, bus.rd_data_o);
                end
            end
        end
        bus.req_pending_i = '0;
        vectors++;
        if (!seen || oe_n != 5) begin errors++; $display("FAIL read_summary done_seen=%b oe_clocks=%0d want 1/5", seen, oe_n); end
    endtask

    task automatic test_write;
        int we_n = 0;
        bit seen = 1'b0;
        bus.req_rw_b_i[1] = 1'b0; bus.req_addr_i[1] = 17'h0E80E; bus.req_wr_data_i[1] = 8'h3C; bus.req_pending_i = 3'b010;
        for (int t = 0; t < 48 && !seen; t++) begin
            @(negedge clk);
            vectors++;
            if (bus.ram_oe_o !== 1'b0) begin errors++; $display("FAIL write_no_oe ram_oe=%b want 0", bus.ram_oe_o); end
            if (bus.ram_we_o) begin
                we_n++; vectors++;
                if (bus.bus_data_oe_o !== 1'b1 || bus.bus_data_o !== 8'h3C || bus.bus_addr_o !== 17'h0E80E || bus.bus_rw_b_o !== 1'b0) begin
                    errors++; $display("FAIL write_drive doe=%b data=%h addr=%h rw=%b want 1/3c/0e80e/0", bus.bus_data_oe_o, bus.bus_data_o, bus.bus_addr_o, bus.bus_rw_b_o);
                end
            end
            if (bus.done_o !== '0) begin
                seen = 1'b1; vectors++;
                if (bus.done_o !== 3'b010 || bus.bus_data_oe_o !== 1'b0) begin
                    errors++; $display("FAIL write_done done=%b doe=%b want 010/0", bus.done_o, bus.bus_data_oe_o);
                end
            end
        end
        bus.req_pending_i = '0;
        vectors++;
        if (!seen || we_n != 5) begin errors++; $display("FAIL write_summary done_seen=%b we_clocks=%0d want 1/5", seen, we_n); end
    endtask

    task automatic test_all_pending;
        logic [N-1:0] want [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
        int k = 0;
        rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
        bus.req_rw_b_i = '1; bus.req_pending_i = 3'b111;
        for (int t = 0; t < 100 && k < 4; t++) begin
            @(negedge clk);
            if (m_cnt == 0) begin
                vectors++;
                if (bus.grant_o !== want[k]) begin errors++; $display("FAIL rr_order slot=%0d grant=%b want %b", k, bus.grant_o, want[k]); end
                k++;
            end
        end
        bus.req_pending_i = '0;
        vectors++;
        if (k != 4) begin errors++; $display("FAIL rr_timeout slots=%0d want 4", k); end
    endtask

    task automatic test_reset_mid;
        bit found = 1'b0;
        rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
        bus.req_rw_b_i = 3'b000; bus.req_wr_data_i[0] = 8'h11; bus.req_wr_data_i[1] = 8'h77; bus.req_pending_i = 3'b001;
        for (int t = 0; t < 48 && !found; t++) begin
            @(negedge clk);
            found = bus.done_o[0];
        end
        bus.req_pending_i = 3'b010;
        found = 1'b0;
        for (int t = 0; t < 48 && !found; t++) begin
            @(negedge clk);
            found = m_off == 3 && bus.ram_we_o && bus.grant_o == 3'b010;
        end
        vectors++;
        if (!found) begin errors++; $display("FAIL abort_setup write on ch1 not reached clock 3"); end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({bus.ram_we_o, bus.ram_oe_o, bus.bus_data_oe_o, bus.bus_addr_oe_o, bus.grant_o, bus.done_o} !== '0) begin
            errors++; $display("FAIL abort_async we=%b doe=%b aoe=%b grant=%b done=%b want all 0", bus.ram_we_o, bus.bus_data_oe_o, bus.bus_addr_oe_o, bus.grant_o, bus.done_o);
        end
        @(negedge clk);
        vectors++;
        if (bus.done_o !== '0) begin errors++; $display("FAIL abort_no_done done=%b want 000", bus.done_o); end
        rst_n = 1'b1;
        bus.req_pending_i = 3'b011;
        found = 1'b0;
        for (int t = 0; t < 48 && !found; t++) begin
            @(negedge clk);
            found = bus.grant_o != '0;
        end
        vectors++;
        if (bus.grant_o !== 3'b001) begin errors++; $display("FAIL abort_restart grant=%b want 001", bus.grant_o); end
        bus.req_pending_i = '0;
    endtask

`ifdef BUS_ARB_CPU_STEAL_EN
    task automatic test_steal;
        bit found = 1'b0;
        rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
        bus.cpu_ready_i = 1'b0; bus.req_rw_b_i = '1; bus.req_pending_i = '0;
        for (int t = 0; t < 40 && !found; t++) begin
            @(negedge clk);
            found = m_cnt == C - 1;
        end
        bus.req_pending_i = 3'b101;
        repeat (C) begin
            @(negedge clk);
            vectors++;
            if (bus.cpu_en_o !== 1'b0) begin errors++; $display("FAIL steal_cpu_en cnt=%0d cpu_en=%b want 0", m_cnt, bus.cpu_en_o); end
            if (m_cnt == H - 1) begin
                vectors++;
                if (bus.done_o !== 3'b001) begin errors++; $display("FAIL steal_aux_done done=%b want 001", bus.done_o); end
            end
            if (m_cnt == C - 1) begin
                vectors++;
                if (bus.done_o !== 3'b100) begin errors++; $display("FAIL steal_cpu_done done=%b want 100", bus.done_o); end
            end
        end
        bus.req_pending_i = '0;
        bus.cpu_ready_i = 1'b1;
    endtask
`endif

    task automatic test_random;
        repeat (600) begin
            @(negedge clk);
            vectors++;
            if ({bus.phi2_o, bus.cpu_en_o, bus.grant_o, bus.done_o, bus.ram_oe_o, bus.ram_we_o, bus.bus_addr_oe_o, bus.bus_data_oe_o, bus.bus_rw_b_o, bus.rd_data_o}
                !== {exp_phi2, exp_cpu_en, exp_grant, exp_done, exp_oe, exp_we, exp_addr_oe, exp_data_oe, exp_rw, m_rd}) begin
                errors++;
                $display("FAIL random cnt=%0d got phi2 %b cpu %b gnt %b done %b oe %b we %b aoe %b doe %b rw %b rd %h want %b %b %b %b %b %b %b %b %b %h",
                         m_cnt, bus.phi2_o, bus.cpu_en_o, bus.grant_o, bus.done_o, bus.ram_oe_o, bus.ram_we_o, bus.bus_addr_oe_o, bus.bus_data_oe_o, bus.bus_rw_b_o, bus.rd_data_o,
                         exp_phi2, exp_cpu_en, exp_grant, exp_done, exp_oe, exp_we, exp_addr_oe, exp_data_oe, exp_rw, m_rd);
            end
            if (exp_addr_oe) begin
                vectors++;
                if (bus.bus_addr_o !== m_addr || (!m_rw && bus.bus_data_o !== m_data)) begin
                    errors++; $display("FAIL random_bus addr=%h data=%h want %h/%h", bus.bus_addr_o, bus.bus_data_o, m_addr, m_data);
                end
            end
            bus.req_pending_i = N'($urandom);
            bus.req_rw_b_i = N'($urandom);
            for (int i = 0; i < N; i++) begin
                bus.req_addr_i[i] = AW'($urandom);
                bus.req_wr_data_i[i] = DW'($urandom);
            end
            bus.bus_data_i = DW'($urandom);
            if ($urandom_range(0, 15) == 0) bus.cpu_ready_i = !bus.cpu_ready_i;
        end
    endtask

    initial begin
        bus.cpu_ready_i = 1'b1; bus.req_pending_i = '0; bus.req_rw_b_i = '1;
        bus.req_addr_i = '0; bus.req_wr_data_i = '0; bus.bus_data_i = '0;
        test_reset();
        test_idle();
        test_read();
        test_write();
        test_all_pending();
        test_reset_mid();
`ifdef BUS_ARB_CPU_STEAL_EN
        test_steal();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
